// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bus_arbiter
//  Purpose  : Shares one register-bus slave port between N_REQ masters.
//             Round-robin grant, one transaction in flight, registered slave
//             outputs, and a timeout that error-completes a transaction when
//             the slave never acknowledges.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1              clock, rising edge
//    reset      in   1              asynchronous, active-high
//    req_cs     in   N_REQ          per-requester request level
//    req_we     in   N_REQ          1=write, 0=read
//    req_addr   in   N_REQ*ADDR_W   packed, requester i at [i*ADDR_W +: ADDR_W]
//    req_wdata  in   N_REQ*DATA_W   packed, same packing
//    req_ack    out  N_REQ          one-cycle completion pulse to the owner
//    req_err    out  1              valid with req_ack, 1 = timed out
//    req_rdata  out  DATA_W         read data, valid with req_ack, then held
//    grant      out  N_REQ          one-hot owner, grant through completion
//    m_cs       out  1              slave select
//    m_we       out  1              slave write enable
//    m_addr     out  ADDR_W         slave address
//    m_wdata    out  DATA_W         slave write data
//    m_rdata    in   DATA_W         slave read data, sampled with m_ack
//    m_ack      in   1              slave completion
// ============================================================================
module reg_bus_arbiter #(
   parameter int N_REQ   = 2,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_cs,
   input  logic [N_REQ-1:0]          req_we,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          req_ack,
   output logic                      req_err,
   output logic [DATA_W-1:0]         req_rdata,
   output logic [N_REQ-1:0]          grant,
   output logic                      m_cs,
   output logic                      m_we,
   output logic [ADDR_W-1:0]         m_addr,
   output logic [DATA_W-1:0]         m_wdata,
   input  logic [DATA_W-1:0]         m_rdata,
   input  logic                      m_ack
);

   localparam int SEL_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [N_REQ-1:0] GRANT_ONE = N_REQ'(1);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N_REQ - 1);
   localparam logic [SEL_W:0]   N_WIDE    = (SEL_W+1)'(N_REQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state,     state_nx;
   logic [SEL_W-1:0]     sel,       sel_nx;
   logic [SEL_W-1:0]     rr_ptr,    rr_ptr_nx;
   logic [CNT_W-1:0]     cnt,       cnt_nx;
   logic [N_REQ-1:0]     grant_nx;
   logic [N_REQ-1:0]     req_ack_nx;
   logic                 req_err_nx;
   logic [DATA_W-1:0]    req_rdata_nx;
   logic                 m_cs_nx;
   logic                 m_we_nx;
   logic [ADDR_W-1:0]    m_addr_nx;
   logic [DATA_W-1:0]    m_wdata_nx;

   // Round-robin pick
   logic                 any_req;
   logic [SEL_W-1:0]     pick;
   logic [SEL_W:0]       rr_sum;
   logic [SEL_W-1:0]     cand;

   // Per-requester views of the packed address / data buses
   logic [ADDR_W-1:0]    addr_arr  [N_REQ];
   logic [DATA_W-1:0]    wdata_arr [N_REQ];

   generate
      for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
         assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
         assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
      end
   endgenerate

   // Search upward from rr_ptr with wrap. Walking the offsets from the far
   // end down to zero lets the smallest offset (highest priority) be the
   // last assignment and therefore the one that sticks.
   always_comb begin
      any_req = |req_cs;
      pick    = rr_ptr;
      rr_sum  = '0;
      cand    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         rr_sum = {1'b0, rr_ptr} + (SEL_W+1)'(i);
         if (rr_sum >= N_WIDE) begin
            rr_sum = rr_sum - N_WIDE;
         end
         cand = rr_sum[SEL_W-1:0];
         if (req_cs[cand]) begin
            pick = cand;
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nx     = state;
      sel_nx       = sel;
      rr_ptr_nx    = rr_ptr;
      cnt_nx       = cnt;
      grant_nx     = grant;
      req_ack_nx   = '0;
      req_err_nx   = req_err;
      req_rdata_nx = req_rdata;
      m_cs_nx      = m_cs;
      m_we_nx      = m_we;
      m_addr_nx    = m_addr;
      m_wdata_nx   = m_wdata;

      case (state)
         ST_IDLE: begin
            cnt_nx = '0;
            if (any_req) begin
               state_nx   = ST_BUSY;
               sel_nx     = pick;
               grant_nx   = GRANT_ONE << pick;
               m_cs_nx    = 1'b1;
               m_we_nx    = req_we[pick];
               m_addr_nx  = addr_arr[pick];
               m_wdata_nx = wdata_arr[pick];
            end
         end

         ST_BUSY: begin
            // A slave ack beats a timeout arriving on the same cycle.
            if (m_ack || (cnt == CNT_LAST)) begin
               state_nx     = ST_DONE;
               req_ack_nx   = grant;
               req_err_nx   = ~m_ack;
               req_rdata_nx = (m_ack && !m_we) ? m_rdata : '0;
               m_cs_nx      = 1'b0;
               m_we_nx      = 1'b0;
               m_addr_nx    = '0;
               m_wdata_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end

         ST_DONE: begin
            state_nx   = ST_IDLE;
            req_err_nx = 1'b0;
            grant_nx   = '0;
            rr_ptr_nx  = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
         end

         default: begin
            state_nx   = ST_IDLE;
            grant_nx   = '0;
            req_err_nx = 1'b0;
            m_cs_nx    = 1'b0;
            m_we_nx    = 1'b0;
            m_addr_nx  = '0;
            m_wdata_nx = '0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         sel       <= '0;
         rr_ptr    <= '0;
         cnt       <= '0;
         grant     <= '0;
         req_ack   <= '0;
         req_err   <= 1'b0;
         req_rdata <= '0;
         m_cs      <= 1'b0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
      end else begin
         state     <= state_nx;
         sel       <= sel_nx;
         rr_ptr    <= rr_ptr_nx;
         cnt       <= cnt_nx;
         grant     <= grant_nx;
         req_ack   <= req_ack_nx;
         req_err   <= req_err_nx;
         req_rdata <= req_rdata_nx;
         m_cs      <= m_cs_nx;
         m_we      <= m_we_nx;
         m_addr    <= m_addr_nx;
         m_wdata   <= m_wdata_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_bus_arbiter
//  Purpose  : Directed self-checking bench for reg_bus_arbiter (N_REQ=2,
//             TIMEOUT=8). One task per scenario with hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_bus_arbiter;

   localparam int N_REQ   = 2;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 8;

   logic                    clk;
   logic                    reset;
   logic [N_REQ-1:0]        req_cs;
   logic [N_REQ-1:0]        req_we;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_ack;
   logic                    req_err;
   logic [DATA_W-1:0]       req_rdata;
   logic [N_REQ-1:0]        grant;
   logic                    m_cs;
   logic                    m_we;
   logic [ADDR_W-1:0]       m_addr;
   logic [DATA_W-1:0]       m_wdata;
   logic [DATA_W-1:0]       m_rdata;
   logic                    m_ack;

   int passed;
   int total;

   reg_bus_arbiter #(
      .N_REQ   (N_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_cs    (req_cs),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ack   (req_ack),
      .req_err   (req_err),
      .req_rdata (req_rdata),
      .grant     (grant),
      .m_cs      (m_cs),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata),
      .m_ack     (m_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      total++;
      if ({req_ack, req_err, grant, m_cs, m_we} !== 7'b0) begin
         $display("FAIL reset_ctrl: got %b want 0", {req_ack, req_err, grant, m_cs, m_we});
      end else passed++;
      total++;
      if ({m_addr, m_wdata, req_rdata} !== '0) begin
         $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", m_addr, m_wdata, req_rdata);
      end else passed++;
   endtask

   task automatic test_write_req0();
      req_cs = 2'b01; req_we = 2'b01;
      req_addr[7:0] = 8'h10; req_wdata[31:0] = 32'hDEADBEEF;
      tick();
      total++;
      if ({m_cs, m_we, m_addr, m_wdata, grant} !== {1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 2'b01}) begin
         $display("FAIL t1_issue: cs=%b we=%b addr=%h wdata=%h grant=%b", m_cs, m_we, m_addr, m_wdata, grant);
      end else passed++;
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      total++;
      if ({req_ack, req_err, m_cs, grant} !== {2'b01, 1'b0, 1'b0, 2'b01}) begin
         $display("FAIL t1_ack: ack=%b err=%b cs=%b grant=%b want 01/0/0/01", req_ack, req_err, m_cs, grant);
      end else passed++;
      req_cs = 2'b00;
      tick();
      total++;
      if ({req_ack, grant, m_addr} !== {2'b00, 2'b00, 8'h00}) begin
         $display("FAIL t1_idle: ack=%b grant=%b addr=%h want 0", req_ack, grant, m_addr);
      end else passed++;
   endtask

   task automatic test_read_req1();
      bit we_seen;
      we_seen = 1'b0;
      req_cs = 2'b10; req_we = 2'b00;
      req_addr[15:8] = 8'h04;
      tick();
      total++;
      if ({m_cs, m_addr, grant} !== {1'b1, 8'h04, 2'b10}) begin
         $display("FAIL t2_issue: cs=%b addr=%h grant=%b want 1/04/10", m_cs, m_addr, grant);
      end else passed++;
      for (int i = 0; i < 2; i++) begin
         if (m_we !== 1'b0 || req_ack !== 2'b00 || m_cs !== 1'b1) we_seen = 1'b1;
         tick();
      end
      if (m_we !== 1'b0 || req_ack !== 2'b00 || m_cs !== 1'b1) we_seen = 1'b1;
      total++;
      if (we_seen) begin
         $display("FAIL t2_wait: got early ack or m_we high, want quiet busy");
      end else passed++;
      m_rdata = 32'h12345678; m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      total++;
      if ({req_ack, req_err, req_rdata} !== {2'b10, 1'b0, 32'h12345678}) begin
         $display("FAIL t2_ack: ack=%b err=%b rdata=%h want 10/0/12345678", req_ack, req_err, req_rdata);
      end else passed++;
      req_cs = 2'b00;
      tick();
      total++;
      if ({req_ack, grant} !== 4'b0000) begin
         $display("FAIL t2_idle: ack=%b grant=%b want 0", req_ack, grant);
      end else passed++;
   endtask

   task automatic test_round_robin();
      logic [N_REQ-1:0] order [4];
      order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
      req_cs = 2'b11; req_we = 2'b00;
      req_addr = 16'h2221;
      m_rdata = 32'hA5A50001; m_ack = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();
         total++;
         if (grant !== order[t]) begin
            $display("FAIL t3_grant%0d: got %b want %b", t, grant, order[t]);
         end else passed++;
         tick();
         total++;
         if (req_ack !== order[t]) begin
            $display("FAIL t3_ack%0d: got %b want %b", t, req_ack, order[t]);
         end else passed++;
         tick();
      end
      req_cs = 2'b00; m_ack = 1'b0;
      total++;
      if (req_rdata !== 32'hA5A50001) begin
         $display("FAIL t3_rdata: got %h want a5a50001", req_rdata);
      end else passed++;
   endtask

   task automatic test_timeout();
      bit early;
      early = 1'b0;
      req_cs = 2'b01; req_we = 2'b00; req_addr[7:0] = 8'h20;
      tick();
      total++;
      if (m_cs !== 1'b1) begin
         $display("FAIL t4_issue: m_cs=%b want 1", m_cs);
      end else passed++;
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         tick();
         if (req_ack !== 2'b00 || m_cs !== 1'b1) early = 1'b1;
      end
      total++;
      if (early) begin
         $display("FAIL t4_early: completion before %0d cycles", TIMEOUT);
      end else passed++;
      tick();
      total++;
      if ({req_ack, req_err, req_rdata, m_cs} !== {2'b01, 1'b1, 32'h0, 1'b0}) begin
         $display("FAIL t4_timeout: ack=%b err=%b rdata=%h cs=%b want 01/1/0/0", req_ack, req_err, req_rdata, m_cs);
      end else passed++;
      req_cs = 2'b00;
      tick();
      total++;
      if ({req_ack, req_err, grant} !== 5'b0) begin
         $display("FAIL t4_clear: ack=%b err=%b grant=%b want 0", req_ack, req_err, grant);
      end else passed++;
      // Next request served normally
      req_cs = 2'b10; req_we = 2'b10; req_addr[15:8] = 8'h44; req_wdata[63:32] = 32'h0BADF00D;
      tick();
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      total++;
      if ({req_ack, req_err, req_rdata} !== {2'b10, 1'b0, 32'h0}) begin
         $display("FAIL t4_next: ack=%b err=%b rdata=%h want 10/0/0", req_ack, req_err, req_rdata);
      end else passed++;
      req_cs = 2'b00;
      tick();
   endtask

   task automatic test_reset_busy();
      req_cs = 2'b01; req_we = 2'b01; req_addr[7:0] = 8'h66; req_wdata[31:0] = 32'h11112222;
      tick();
      total++;
      if (m_cs !== 1'b1) begin
         $display("FAIL t5_busy: m_cs=%b want 1", m_cs);
      end else passed++;
      reset = 1'b1;
      #1;
      total++;
      if ({req_ack, req_err, grant, m_cs, m_we, m_addr, m_wdata, req_rdata} !== '0) begin
         $display("FAIL t5_async: ack=%b grant=%b cs=%b addr=%h want 0", req_ack, grant, m_cs, m_addr);
      end else passed++;
      req_cs = 2'b00;
      tick();
      reset = 1'b0;
      m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
      tick();
      tick();
      m_ack = 1'b0;
      total++;
      if ({req_ack, grant, m_cs, req_rdata} !== {2'b00, 2'b00, 1'b0, 32'h0}) begin
         $display("FAIL t5_stray: ack=%b grant=%b cs=%b rdata=%h want 0", req_ack, grant, m_cs, req_rdata);
      end else passed++;
   endtask

   task automatic test_addr_stable();
      req_cs = 2'b10; req_we = 2'b10; req_addr[15:8] = 8'h30; req_wdata[63:32] = 32'hCAFE0001;
      tick();
      req_addr[15:8] = 8'h55; req_wdata[63:32] = 32'h99999999; req_we = 2'b00;
      tick();
      tick();
      total++;
      if ({m_addr, m_wdata, m_we, m_cs} !== {8'h30, 32'hCAFE0001, 1'b1, 1'b1}) begin
         $display("FAIL t6_stable: addr=%h wdata=%h we=%b want 30/cafe0001/1", m_addr, m_wdata, m_we);
      end else passed++;
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      total++;
      if (req_ack !== 2'b10) begin
         $display("FAIL t6_ack: got %b want 10", req_ack);
      end else passed++;
      req_cs = 2'b00;
      tick();
   endtask

   initial begin
      passed = 0; total = 0;
      reset = 1'b1;
      req_cs = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      m_rdata = '0; m_ack = 1'b0;
      tick();
      tick();
      test_reset();
      reset = 1'b0;
      tick();
      test_write_req0();
      test_read_req1();
      test_round_robin();
      test_timeout();
      test_reset_busy();
      test_addr_stable();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
